// File: rtl/riscv_multicycle_ctrl_pkg.sv
// Shared definitions for the multicycle RV32I control unit: state codes,
// opcodes and the encodings of every datapath select driven by the controller.
// Optional feature macro: RISCV_ILLEGAL_TRAP_EN adds the TRAP state.
package riscv_multicycle_ctrl_pkg;

   typedef enum logic [3:0] {
      S_FETCH    = 4'd0,
      S_DECODE   = 4'd1,
      S_MEMADR   = 4'd2,
      S_MEMREAD  = 4'd3,
      S_MEMWB    = 4'd4,
      S_MEMWRITE = 4'd5,
      S_EXECUTER = 4'd6,
      S_EXECUTEI = 4'd7,
      S_ALUWB    = 4'd8,
      S_BEQ      = 4'd9,
      S_JAL      = 4'd10
`ifdef RISCV_ILLEGAL_TRAP_EN
      , S_TRAP   = 4'd11
`endif
   } state_t;

   // Opcodes taken from IR[6:0]
   localparam logic [6:0] OP_LW  = 7'b0000011;
   localparam logic [6:0] OP_SW  = 7'b0100011;
   localparam logic [6:0] OP_R   = 7'b0110011;
   localparam logic [6:0] OP_I   = 7'b0010011;
   localparam logic [6:0] OP_BEQ = 7'b1100011;
   localparam logic [6:0] OP_JAL = 7'b1101111;

   // ALUControl encodings
   localparam logic [2:0] ALU_ADD = 3'b000;
   localparam logic [2:0] ALU_SUB = 3'b001;
   localparam logic [2:0] ALU_AND = 3'b010;
   localparam logic [2:0] ALU_OR  = 3'b011;
   localparam logic [2:0] ALU_SLT = 3'b101;

   // ALUOp: request from the main FSM to the ALU decoder
   localparam logic [1:0] ALUOP_ADD   = 2'b00;
   localparam logic [1:0] ALUOP_SUB   = 2'b01;
   localparam logic [1:0] ALUOP_FUNCT = 2'b10;

   // ResultSrc encodings
   localparam logic [1:0] RES_ALUOUT    = 2'b00;
   localparam logic [1:0] RES_DATA      = 2'b01;
   localparam logic [1:0] RES_ALURESULT = 2'b10;

   // ALUSrcA encodings
   localparam logic [1:0] SRCA_PC    = 2'b00;
   localparam logic [1:0] SRCA_OLDPC = 2'b01;
   localparam logic [1:0] SRCA_RD1   = 2'b10;

   // ALUSrcB encodings
   localparam logic [1:0] SRCB_RD2  = 2'b00;
   localparam logic [1:0] SRCB_IMM  = 2'b01;
   localparam logic [1:0] SRCB_FOUR = 2'b10;

   // ImmSrc encodings (J-type, 2'b11, is never selected by this controller)
   localparam logic [1:0] IMM_I = 2'b00;
   localparam logic [1:0] IMM_S = 2'b01;
   localparam logic [1:0] IMM_B = 2'b10;

endpackage

// File: rtl/riscv_multicycle_ctrl_alu_decoder.sv
// ALU decoder: turns the FSM's ALUOp request plus the instruction funct
// fields into the 3-bit ALUControl code.
module riscv_alu_decoder
   import riscv_multicycle_ctrl_pkg::*;
(
   input  logic [1:0] ALUOp,
   input  logic [2:0] Funct3,
   input  logic       Funct7b5,
   input  logic       Op5,
   output logic [2:0] ALUControl
);

   // Select the ALU operation; only register-register sub sets Op5 and Funct7b5 together
   always_comb begin
      ALUControl = ALU_ADD;
      case (ALUOp)
         ALUOP_SUB:   ALUControl = ALU_SUB;
         ALUOP_FUNCT: begin
            case (Funct3)
               3'b000:  ALUControl = (Op5 & Funct7b5) ? ALU_SUB : ALU_ADD;
               3'b010:  ALUControl = ALU_SLT;
               3'b110:  ALUControl = ALU_OR;
               3'b111:  ALUControl = ALU_AND;
               default: ALUControl = ALU_ADD;
            endcase
         end
         default:     ALUControl = ALU_ADD;
      endcase
   end

endmodule

// File: rtl/riscv_multicycle_ctrl.sv
// Main control FSM for the multicycle RV32I datapath. Sequences each
// instruction through fetch/decode/execute/writeback and drives all datapath
// selects and enables. Optional macro RISCV_ILLEGAL_TRAP_EN: unknown opcodes
// park the FSM in TRAP (with Illegal=1) until Reset instead of acting as NOP.
module riscv_multicycle_ctrl
   import riscv_multicycle_ctrl_pkg::*;
#(
   parameter int STATE_W    = 4,
   parameter int RESET_PC_W = 0
) (
   input  logic               clock,
   input  logic               Reset,
   input  logic [6:0]         Op,
   input  logic [2:0]         Funct3,
   input  logic               Funct7b5,
   input  logic               Zero,
   output logic               PCWrite,
   output logic               AdrSrc,
   output logic               MemWrite,
   output logic               IRWrite,
   output logic               RegWrite,
   output logic [1:0]         ResultSrc,
   output logic [1:0]         ALUSrcA,
   output logic [1:0]         ALUSrcB,
   output logic [1:0]         ImmSrc,
   output logic [2:0]         ALUControl,
   output logic [STATE_W-1:0] State
`ifdef RISCV_ILLEGAL_TRAP_EN
   ,
   output logic               Illegal
`endif
);

   state_t     state;
   state_t     state_next;
   state_t     out_state;
   logic [1:0] alu_op;

   // Reset-vector logic belongs to the datapath; RESET_PC_W is unused and stays 0
   if (RESET_PC_W != 0) begin : g_reset_pc_unused
   end

   // State register with synchronous reset back to FETCH
   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clock) begin
      if (Reset) state <= S_FETCH;
      else       state <= state_next;
   end

   // Next-state logic: opcode dispatch in DECODE, fixed successors elsewhere
   // NOTE: state_next gets a default before the case so no path can infer a latch.
   always_comb begin
      state_next = S_FETCH;
      case (state)
         S_FETCH:  state_next = S_DECODE;
         S_DECODE: begin
            case (Op)
               OP_LW, OP_SW: state_next = S_MEMADR;
               OP_R:         state_next = S_EXECUTER;
               OP_I:         state_next = S_EXECUTEI;
               OP_BEQ:       state_next = S_BEQ;
               OP_JAL:       state_next = S_JAL;
`ifdef RISCV_ILLEGAL_TRAP_EN
               default:      state_next = S_TRAP;
`else
               default:      state_next = S_FETCH;
`endif
            endcase
         end
         S_MEMADR:   state_next = (Op == OP_SW) ? S_MEMWRITE : S_MEMREAD;
         S_MEMREAD:  state_next = S_MEMWB;
         S_EXECUTER: state_next = S_ALUWB;
         S_EXECUTEI: state_next = S_ALUWB;
         S_JAL:      state_next = S_ALUWB;
`ifdef RISCV_ILLEGAL_TRAP_EN
         S_TRAP:     state_next = S_TRAP;
`endif
         default:    state_next = S_FETCH;
      endcase
   end

   // Moore outputs; Reset shows FETCH selects and kills every write enable
   always_comb begin
      out_state = Reset ? S_FETCH : state;
      PCWrite   = 1'b0;
      AdrSrc    = 1'b0;
      MemWrite  = 1'b0;
      IRWrite   = 1'b0;
      RegWrite  = 1'b0;
      ResultSrc = RES_ALUOUT;
      ALUSrcA   = SRCA_PC;
      ALUSrcB   = SRCB_RD2;
      ImmSrc    = IMM_I;
      alu_op    = ALUOP_ADD;
`ifdef RISCV_ILLEGAL_TRAP_EN
      Illegal   = 1'b0;
`endif
      case (out_state)
         S_FETCH: begin
            IRWrite   = 1'b1;
            PCWrite   = 1'b1;
            ALUSrcB   = SRCB_FOUR;
            ResultSrc = RES_ALURESULT;
         end
         S_DECODE: begin
            ALUSrcA = SRCA_OLDPC;
            ALUSrcB = SRCB_IMM;
            ImmSrc  = IMM_B;
         end
         S_MEMADR: begin
            ALUSrcA = SRCA_RD1;
            ALUSrcB = SRCB_IMM;
            ImmSrc  = (Op == OP_SW) ? IMM_S : IMM_I;
         end
         S_MEMREAD:  AdrSrc = 1'b1;
         S_MEMWB: begin
            ResultSrc = RES_DATA;
            RegWrite  = 1'b1;
         end
         S_MEMWRITE: begin
            AdrSrc   = 1'b1;
            MemWrite = 1'b1;
         end
         S_EXECUTER: begin
            ALUSrcA = SRCA_RD1;
            alu_op  = ALUOP_FUNCT;
         end
         S_EXECUTEI: begin
            ALUSrcA = SRCA_RD1;
            ALUSrcB = SRCB_IMM;
            alu_op  = ALUOP_FUNCT;
         end
         S_ALUWB:    RegWrite = 1'b1;
         S_BEQ: begin
            ALUSrcA = SRCA_RD1;
            alu_op  = ALUOP_SUB;
            PCWrite = Zero;
         end
         S_JAL: begin
            ALUSrcA = SRCA_OLDPC;
            ALUSrcB = SRCB_FOUR;
            PCWrite = 1'b1;
         end
`ifdef RISCV_ILLEGAL_TRAP_EN
         S_TRAP:     Illegal = 1'b1;
`endif
         default: ;
      endcase
      if (Reset) begin
         PCWrite  = 1'b0;
         MemWrite = 1'b0;
         IRWrite  = 1'b0;
         RegWrite = 1'b0;
      end
   end

   assign State = STATE_W'(state);

   riscv_alu_decoder u_alu_decoder (
      .ALUOp      (alu_op),
      .Funct3     (Funct3),
      .Funct7b5   (Funct7b5),
      .Op5        (Op[5]),
      .ALUControl (ALUControl)
   );

endmodule

// File: tb/tb_riscv_multicycle_ctrl.sv
// Testbench for riscv_multicycle_ctrl. A driver issues instructions and pushes
// the expected per-cycle control word into a queue; a monitor on the falling
// edge pops and compares it with the DUT outputs.
module tb_riscv_multicycle_ctrl;

   typedef struct packed {
      logic [3:0] st;
      logic       pcw;
      logic       adr;
      logic       memw;
      logic       irw;
      logic       regw;
      logic [1:0] res;
      logic [1:0] sa;
      logic [1:0] sb;
      logic [1:0] imm;
      logic [2:0] alu;
      logic       ill;
   } exp_t;

   logic       clock = 1'b0;
   logic       Reset = 1'b1;
   logic [6:0] Op = 7'd0;
   logic [2:0] Funct3 = 3'd0;
   logic       Funct7b5 = 1'b0;
   logic       Zero = 1'b0;
   logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite;
   logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
   logic [2:0] ALUControl;
   logic [3:0] State;
   logic       ill_act;

   exp_t  exp_q[$];
   string name_q[$];
   int    n_checks = 0;
   int    n_fail = 0;

   riscv_multicycle_ctrl dut (
      .clock      (clock),
      .Reset      (Reset),
      .Op         (Op),
      .Funct3     (Funct3),
      .Funct7b5   (Funct7b5),
      .Zero       (Zero),
      .PCWrite    (PCWrite),
      .AdrSrc     (AdrSrc),
      .MemWrite   (MemWrite),
      .IRWrite    (IRWrite),
      .RegWrite   (RegWrite),
      .ResultSrc  (ResultSrc),
      .ALUSrcA    (ALUSrcA),
      .ALUSrcB    (ALUSrcB),
      .ImmSrc     (ImmSrc),
      .ALUControl (ALUControl),
      .State      (State)
`ifdef RISCV_ILLEGAL_TRAP_EN
      ,
      .Illegal    (ill_act)
`endif
   );

`ifndef RISCV_ILLEGAL_TRAP_EN
   assign ill_act = 1'b0;
`endif

   always #5 clock = ~clock;

   function automatic exp_t mk(input int st, input bit pcw, input bit adr, input bit memw,
                               input bit irw, input bit regw, input int res, input int sa,
                               input int sb, input int imm, input int alu, input bit ill = 1'b0);
      exp_t r;
      r.st = st[3:0]; r.pcw = pcw; r.adr = adr; r.memw = memw; r.irw = irw; r.regw = regw;
      r.res = res[1:0]; r.sa = sa[1:0]; r.sb = sb[1:0]; r.imm = imm[1:0]; r.alu = alu[2:0];
      r.ill = ill;
      return r;
   endfunction

   function automatic string fmt(input exp_t r);
      return $sformatf("st=%0d pcw=%b adr=%b mw=%b irw=%b rw=%b res=%b sa=%b sb=%b imm=%b alu=%b ill=%b",
                       r.st, r.pcw, r.adr, r.memw, r.irw, r.regw, r.res, r.sa, r.sb, r.imm, r.alu, r.ill);
   endfunction

   // Reference ALU operation for R/I instructions, straight from the funct rules
   function automatic int alu_of(input logic [6:0] op, input logic [2:0] f3, input logic f7);
      case (f3)
         3'b000:  return (op[5] && f7) ? 1 : 0;
         3'b010:  return 5;
         3'b110:  return 3;
         3'b111:  return 2;
         default: return 0;
      endcase
   endfunction

   // Monitor: compare one expected control word per cycle, away from the edge
   always @(negedge clock) begin
      exp_t  e;
      exp_t  a;
      string nm;
      if (exp_q.size() != 0) begin
         e  = exp_q.pop_front();
         nm = name_q.pop_front();
         a  = mk(int'(State), PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, int'(ResultSrc),
                 int'(ALUSrcA), int'(ALUSrcB), int'(ImmSrc), int'(ALUControl), ill_act);
         n_checks++;
         if (a !== e) begin
            n_fail++;
            $display("FAIL %s: got {%s} expected {%s}", nm, fmt(a), fmt(e));
         end
      end
   end

   task automatic step(input exp_t e, input string nm);
      exp_q.push_back(e);
      name_q.push_back(nm);
      @(posedge clock);
      #1;
   endtask

   // Expected control word while Reset is high: FETCH selects, no enables
   function automatic exp_t reset_word(input int st);
      return mk(st, 0, 0, 0, 0, 0, 2, 0, 2, 0, 0);
   endfunction

   // Issue one instruction from FETCH; abort_at >= 0 asserts Reset in that cycle.
   // zsel: -1 random Zero each cycle, otherwise Zero held at that value.
   task automatic issue(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                        input int abort_at, input int zsel, input string tag);
      exp_t seq[$];
      exp_t r;
      int   fa;
      bit   unknown;
      fa      = alu_of(op, f3, f7);
      unknown = 1'b0;
      Op = op; Funct3 = f3; Funct7b5 = f7;
      seq.push_back(mk(0, 1, 0, 0, 1, 0, 2, 0, 2, 0, 0));    // fetch, PC+4
      seq.push_back(mk(1, 0, 0, 0, 0, 0, 0, 1, 1, 2, 0));    // decode, branch target
      case (op)
         7'b0000011: begin
            seq.push_back(mk(2, 0, 0, 0, 0, 0, 0, 2, 1, 0, 0));
            seq.push_back(mk(3, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0));
            seq.push_back(mk(4, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0));
         end
         7'b0100011: begin
            seq.push_back(mk(2, 0, 0, 0, 0, 0, 0, 2, 1, 1, 0));
            seq.push_back(mk(5, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0));
         end
         7'b0110011: begin
            seq.push_back(mk(6, 0, 0, 0, 0, 0, 0, 2, 0, 0, fa));
            seq.push_back(mk(8, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0));
         end
         7'b0010011: begin
            seq.push_back(mk(7, 0, 0, 0, 0, 0, 0, 2, 1, 0, fa));
            seq.push_back(mk(8, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0));
         end
         7'b1100011: seq.push_back(mk(9, 0, 0, 0, 0, 0, 0, 2, 0, 0, 1));
         7'b1101111: begin
            seq.push_back(mk(10, 1, 0, 0, 0, 0, 0, 1, 2, 0, 0));
            seq.push_back(mk(8, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0));
         end
         default: begin
            unknown = 1'b1;
`ifdef RISCV_ILLEGAL_TRAP_EN
            for (int k = 0; k < 10; k++) seq.push_back(mk(11, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1'b1));
`endif
         end
      endcase
      for (int i = 0; i < seq.size(); i++) begin
         Zero = (zsel < 0) ? 1'($urandom_range(0, 1)) : 1'(zsel);
         r = seq[i];
         if (r.st == 4'd9) r.pcw = Zero;
         if (i == abort_at) begin
            Reset = 1'b1;
            step(reset_word(int'(seq[i].st)), $sformatf("%s_abort[%0d]", tag, i));
            Reset = 1'b0;
            return;
         end
         step(r, $sformatf("%s[%0d]", tag, i));
      end
`ifdef RISCV_ILLEGAL_TRAP_EN
      if (unknown) begin
         Reset = 1'b1;
         step(reset_word(11), $sformatf("%s_trap_clear", tag));
         Reset = 1'b0;
      end
`else
      if (unknown) Zero = 1'b0;
`endif
   endtask

   initial begin
      logic [6:0] ops[6];
      logic [6:0] op;
      int         abort_at;
      ops[0] = 7'b0000011; ops[1] = 7'b0100011; ops[2] = 7'b0110011;
      ops[3] = 7'b0010011; ops[4] = 7'b1100011; ops[5] = 7'b1101111;

      // Reset: first edge loads FETCH; check the reset-held word in the next cycle
      Reset = 1'b1;
      @(posedge clock);
      #1;
      step(reset_word(0), "reset");
      Reset = 1'b0;

      // Directed cases
      issue(7'b0000011, 3'b010, 1'b0, -1, -1, "lw");
      issue(7'b0110011, 3'b000, 1'b1, -1, -1, "r_sub");
      issue(7'b0110011, 3'b000, 1'b0, -1, -1, "r_add");
      issue(7'b0110011, 3'b010, 1'b0, -1, -1, "r_slt");
      issue(7'b0110011, 3'b110, 1'b0, -1, -1, "r_or");
      issue(7'b0010011, 3'b000, 1'b1, -1, -1, "i_addi_f7");
      issue(7'b0010011, 3'b111, 1'b0, -1, -1, "i_andi");
      issue(7'b1100011, 3'b000, 1'b0, -1, 1, "beq_taken");
      issue(7'b1100011, 3'b000, 1'b0, -1, 0, "beq_not_taken");
      issue(7'b0100011, 3'b010, 1'b0, -1, -1, "sw");
      issue(7'b1101111, 3'b000, 1'b0, -1, -1, "jal");
      issue(7'b0000011, 3'b010, 1'b0, 3, -1, "lw_abort_memread");
      issue(7'b0000000, 3'b000, 1'b0, -1, -1, "illegal");
      issue(7'b0000011, 3'b010, 1'b0, -1, -1, "lw_after_illegal");

      // Randomized instruction stream with occasional mid-instruction resets
      for (int n = 0; n < 300; n++) begin
         if ($urandom_range(0, 6) == 6) op = 7'($urandom);
         else                           op = ops[$urandom_range(0, 5)];
         abort_at = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 4)) : -1;
         issue(op, 3'($urandom), 1'($urandom), abort_at, -1, $sformatf("rnd%0d_op%b", n, op));
      end

      // Let the monitor drain the last expectations, with a bounded wait
      for (int k = 0; k < 10 && exp_q.size() != 0; k++) @(negedge clock);
      #1;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
